aes_round_scheduler: RTL and testbench

- Controller that shares one iterative AES round datapath among NREQ requesters.
- Arbitrates between requesters round-robin and sequences the datapath from initial AddRoundKey through the final round.
- Drives per-round control strobes: load, round index, key-expansion step, last-round MixColumns bypass.
- Returns a completion handshake tagged with the requester id.
- Sits between the block-request ports and the round-logic cone. It holds no data, only control.

---
 rtl/aes_round_scheduler_pkg.sv | 23 ++
 rtl/aes_sched_rr_arb.sv | 49 ++++
 rtl/aes_round_scheduler.sv | 158 +++++++++++++++
 tb/tb_aes_round_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the AES round scheduler:
//   - sched_state_e : controller state encoding (IDLE, ROUND, DONE)
//   - AES128/192/256_ROUNDS : round counts for the three AES key sizes
//   - RND_W : default width of the round index
// No ports (package).
// ----------------------------------------------------------------------------
package aes_sched_pkg;

   localparam int AES128_ROUNDS = 10;
   localparam int AES192_ROUNDS = 12;
   localparam int AES256_ROUNDS = 14;

   localparam int RND_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } sched_state_e;

endpackage : aes_sched_pkg

// File: rtl/aes_sched_rr_arb.sv
// ----------------------------------------------------------------------------
// aes_sched_rr_arb
// Combinational round-robin priority picker. Grants the first set bit of req
// at or after ptr, wrapping modulo NREQ.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  ID_W  highest-priority index (must be < NREQ)
//   gnt  out NREQ  one-hot grant (all zero when nothing requested)
//   id   out ID_W  encoded index of the granted bit
//   any  out 1     at least one request is set
// ----------------------------------------------------------------------------
module aes_sched_rr_arb #(
   parameter int NREQ = 2,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] id,
   output logic            any
);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   // NOTE: every signal written here gets a default before the loop, so no
   // path through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      gnt = '0;
      id  = '0;
      any = 1'b0;
      sum = '0;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         // Walk indices ptr, ptr+1, ... with a manual modulo-NREQ wrap.
         sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(NREQ)) begin
            sum = sum - (ID_W+1)'(NREQ);
         end
         idx = sum[ID_W-1:0];
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            id       = idx;
         end
      end
   end

endmodule : aes_sched_rr_arb

// File: rtl/aes_round_scheduler.sv
// ----------------------------------------------------------------------------
// aes_round_scheduler
// Control-only sequencer sharing one iterative AES round datapath between
// NREQ requesters. Round-robin grant, initial AddRoundKey load, NUM_ROUNDS
// round strobes, then a response held until accepted.
// Optional build macro: AES_ROUND_SCHED_PERF_EN adds perf_busy_cycles and
// perf_blocks saturating counters.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   req_valid/ready   per-requester request, one-hot combinational accept
//   dp_load           load block + round-0 key, initial AddRoundKey
//   dp_sel            datapath input mux select (granted requester)
//   dp_round_en       execute one round this cycle
//   dp_round          round index 1..NUM_ROUNDS, 0 when no round runs
//   dp_key_step       advance key expansion one round
//   dp_last           final round, bypass MixColumns
//   rsp_valid/id      result present, owning requester
//   rsp_ready         result consumer accept
//   busy              controller not idle
//   perf_busy_cycles  (perf build) cycles with busy high, saturating
//   perf_blocks       (perf build) response handshakes, saturating
// ----------------------------------------------------------------------------
module aes_round_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int ID_W       = $clog2(NREQ),
   parameter int RND_W      = aes_sched_pkg::RND_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   output logic             dp_load,
   output logic [ID_W-1:0]  dp_sel,
   output logic             dp_round_en,
   output logic [RND_W-1:0] dp_round,
   output logic             dp_key_step,
   output logic             dp_last,
   output logic             rsp_valid,
   output logic [ID_W-1:0]  rsp_id,
   input  logic             rsp_ready,
   output logic             busy
`ifdef AES_ROUND_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_busy_cycles,
   output logic [15:0]      perf_blocks
`endif
);

   sched_state_e     state;
   logic [RND_W-1:0] round;
   logic [ID_W-1:0]  gnt_id;
   logic [ID_W-1:0]  rr_ptr;

   logic [ID_W-1:0]  next_ptr;
   logic [ID_W-1:0]  arb_ptr;
   logic [ID_W-1:0]  arb_id;
   logic [NREQ-1:0]  arb_req;
   logic [NREQ-1:0]  arb_gnt;
   logic             arb_any;
   logic             grant_ok;
   logic             in_round;
   logic             last_round;
   logic             rsp_hs;

   // Pointer value that a response handshake installs; the back-to-back grant
   // in DONE uses it combinationally before it reaches rr_ptr.
   assign next_ptr = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);

   // A grant may happen from IDLE, or from DONE in the handshake cycle. The
   // rst term keeps req_ready/dp_load low while reset is held, since they are
   // otherwise combinational from req_valid.
   assign grant_ok = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && rsp_ready));
   assign arb_req  = grant_ok ? req_valid : '0;
   assign arb_ptr  = (state == ST_DONE) ? next_ptr : rr_ptr;

   aes_sched_rr_arb #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req (arb_req),
      .ptr (arb_ptr),
      .gnt (arb_gnt),
      .id  (arb_id),
      .any (arb_any)
   );

   assign in_round    = (state == ST_ROUND);
   assign last_round  = (round == RND_W'(NUM_ROUNDS));
   assign rsp_hs      = rsp_valid && rsp_ready;

   assign req_ready   = arb_gnt;
   assign dp_load     = arb_any;
   assign dp_sel      = arb_any ? arb_id : (in_round ? gnt_id : '0);
   assign dp_round_en = in_round;
   assign dp_key_step = in_round;
   assign dp_round    = in_round ? round : '0;
   assign dp_last     = in_round && last_round;
   assign rsp_valid   = (state == ST_DONE);
   assign rsp_id      = rsp_valid ? gnt_id : '0;
   assign busy        = (state != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         round  <= '0;
         gnt_id <= '0;
         rr_ptr <= '0;
      end else begin
         // Pointer moves on response handshake only, never on grant.
         if (rsp_hs) begin
            rr_ptr <= next_ptr;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (arb_any) begin
                  gnt_id <= arb_id;
                  round  <= RND_W'(1);
                  state  <= ST_ROUND;
               end else if (rsp_hs) begin
                  round  <= '0;
                  state  <= ST_IDLE;
               end
            end
            ST_ROUND: begin
               // Leave on the last round so the counter never passes NUM_ROUNDS.
               if (last_round) begin
                  state <= ST_DONE;
               end else begin
                  round <= round + RND_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef AES_ROUND_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy_cycles <= '0;
         perf_blocks      <= '0;
      end else begin
         if (busy && (perf_busy_cycles != '1)) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         end
         if (rsp_hs && (perf_blocks != '1)) begin
            perf_blocks <= perf_blocks + 16'd1;
         end
      end
   end
`endif

endmodule : aes_round_scheduler

// File: tb/tb_aes_round_scheduler.sv
// ----------------------------------------------------------------------------
// tb_aes_round_scheduler
// Directed self-checking bench for aes_round_scheduler. Instance dut uses the
// defaults (NREQ=2, 10 rounds); instance dut14 uses NREQ=4, 14 rounds.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Perf-counter checks exist only when
// AES_ROUND_SCHED_PERF_EN is defined.
// ----------------------------------------------------------------------------
module tb_aes_round_scheduler;

   logic       clk;
   logic       rst;

   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic       dp_load;
   logic [0:0] dp_sel;
   logic       dp_round_en;
   logic [3:0] dp_round;
   logic       dp_key_step;
   logic       dp_last;
   logic       rsp_valid;
   logic [0:0] rsp_id;
   logic       rsp_ready;
   logic       busy;

   logic [3:0] req_valid14;
   logic [3:0] req_ready14;
   logic       dp_load14;
   logic [1:0] dp_sel14;
   logic       dp_round_en14;
   logic [3:0] dp_round14;
   logic       dp_key_step14;
   logic       dp_last14;
   logic       rsp_valid14;
   logic [1:0] rsp_id14;
   logic       rsp_ready14;
   logic       busy14;

`ifdef AES_ROUND_SCHED_PERF_EN
   logic [31:0] perf_busy_cycles;
   logic [15:0] perf_blocks;
   logic [31:0] perf_busy_cycles14;
   logic [15:0] perf_blocks14;
`endif

   int checks = 0;
   int errors = 0;

   aes_round_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .dp_load     (dp_load),
      .dp_sel      (dp_sel),
      .dp_round_en (dp_round_en),
      .dp_round    (dp_round),
      .dp_key_step (dp_key_step),
      .dp_last     (dp_last),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_ready   (rsp_ready),
      .busy        (busy)
`ifdef AES_ROUND_SCHED_PERF_EN
      ,
      .perf_busy_cycles (perf_busy_cycles),
      .perf_blocks      (perf_blocks)
`endif
   );

   aes_round_scheduler #(
      .NREQ       (4),
      .NUM_ROUNDS (14)
   ) dut14 (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid14),
      .req_ready   (req_ready14),
      .dp_load     (dp_load14),
      .dp_sel      (dp_sel14),
      .dp_round_en (dp_round_en14),
      .dp_round    (dp_round14),
      .dp_key_step (dp_key_step14),
      .dp_last     (dp_last14),
      .rsp_valid   (rsp_valid14),
      .rsp_id      (rsp_id14),
      .rsp_ready   (rsp_ready14),
      .busy        (busy14)
`ifdef AES_ROUND_SCHED_PERF_EN
      ,
      .perf_busy_cycles (perf_busy_cycles14),
      .perf_blocks      (perf_blocks14)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      req_valid   = '0;
      rsp_ready   = 1'b0;
      req_valid14 = '0;
      rsp_ready14 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Ten round cycles of dut; rv is applied in the first of them (after the
   // grant edge), sel is the requester expected on dp_sel.
   task automatic rounds10(input string tag, input logic [1:0] rv, input int sel);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) req_valid = rv;
         @(negedge clk);
         check({tag, "_round"}, 32'(dp_round), 32'(k));
         check({tag, "_last"},  32'(dp_last),  32'(k == 10));
         check({tag, "_sel"},   32'(dp_sel),   32'(sel));
      end
   endtask

   task automatic rounds14(input string tag, input logic [3:0] rv, input int sel);
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) req_valid14 = rv;
         @(negedge clk);
         check({tag, "_round"}, 32'(dp_round14), 32'(k));
         check({tag, "_last"},  32'(dp_last14),  32'(k == 14));
         check({tag, "_sel"},   32'(dp_sel14),   32'(sel));
      end
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = '0;
      rsp_ready   = 1'b0;
      req_valid14 = '0;
      rsp_ready14 = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("rst_busy",      32'(busy),        32'd0);
      check("rst_round_en",  32'(dp_round_en), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
      do_reset();

      // ---------------- single request, rsp_ready=1 ----------------
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t1_ready", 32'(req_ready), 32'b01);
      check("t1_load",  32'(dp_load),   32'd1);
      check("t1_sel",   32'(dp_sel),    32'd0);
      check("t1_idle_round", 32'(dp_round), 32'd0);
      rounds10("t1", 2'b00, 0);
      tick();
      @(negedge clk);
      check("t1_rsp_valid", 32'(rsp_valid),   32'd1);
      check("t1_rsp_id",    32'(rsp_id),      32'd0);
      check("t1_done_en",   32'(dp_round_en), 32'd0);
      tick();
      @(negedge clk);
      check("t1_busy_after", 32'(busy),      32'd0);
      check("t1_rsp_after",  32'(rsp_valid), 32'd0);

      // ---------------- backpressure (pointer now 1, wraps to 0) ----------------
      tick();
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'b01);
      check("bp_keystep_idle", 32'(dp_key_step), 32'd0);
      rounds10("bp", 2'b00, 0);
      for (int c = 11; c <= 15; c++) begin
         tick();
         if (c == 15) rsp_ready = 1'b1;
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_id",    32'(rsp_id),    32'd0);
         check("bp_busy",      32'(busy),      32'd1);
      end
      tick();
      @(negedge clk);
      check("bp_idle", 32'(busy), 32'd0);

      // ---------------- contention fairness ----------------
      do_reset();
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("fair_ready0", 32'(req_ready), 32'b01);
      check("fair_load0",  32'(dp_load),   32'd1);
      for (int g = 1; g <= 3; g++) begin
         rounds10("fair", 2'b11, (g - 1) % 2);
         tick();
         @(negedge clk);
         check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
         check("fair_rsp_id",    32'(rsp_id),    32'((g - 1) % 2));
         check("fair_b2b_load",  32'(dp_load),   32'd1);
         check("fair_sel",       32'(dp_sel),    32'(g % 2));
         check("fair_ready",     32'(req_ready), (g % 2 == 1) ? 32'b10 : 32'b01);
      end

      // ---------------- reset mid-block (round 5 of the block at cycle 33) ----------------
      for (int k = 1; k <= 5; k++) begin
         tick();
      end
      @(negedge clk);
      check("mid_round_pre", 32'(dp_round), 32'd5);
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_busy",   32'(busy),        32'd0);
      check("mid_rst_en",     32'(dp_round_en), 32'd0);
      check("mid_rst_round",  32'(dp_round),    32'd0);
      check("mid_rst_ready",  32'(req_ready),   32'd0);
      check("mid_rst_load",   32'(dp_load),     32'd0);
      check("mid_rst_rsp",    32'(rsp_valid),   32'd0);
      check("mid_rst_sel",    32'(dp_sel),      32'd0);
      req_valid = 2'b00;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("mid_post_rsp",  32'(rsp_valid), 32'd0);
         check("mid_post_busy", 32'(busy),      32'd0);
         tick();
      end
      req_valid = 2'b11;
      @(negedge clk);
      check("mid_ptr_zero", 32'(req_ready), 32'b01);

      // ---------------- NUM_ROUNDS=14, NREQ=4 ----------------
      do_reset();
      req_valid14 = 4'b1000;
      rsp_ready14 = 1'b1;
      @(negedge clk);
      check("r14_ready", 32'(req_ready14), 32'b1000);
      check("r14_load",  32'(dp_load14),   32'd1);
      check("r14_sel",   32'(dp_sel14),    32'd3);
      rounds14("r14", 4'b0000, 3);
      tick();
      @(negedge clk);
      check("r14_rsp_valid", 32'(rsp_valid14), 32'd1);
      check("r14_rsp_id",    32'(rsp_id14),    32'd3);
      // Pointer wrapped from 3 to 0.
      tick();
      req_valid14 = 4'b0101;
      @(negedge clk);
      check("r14_wrap_ready", 32'(req_ready14), 32'b0001);
      rounds14("r14b", 4'b0100, 0);
      tick();
      @(negedge clk);
      check("r14_b2b_rsp_id", 32'(rsp_id14),    32'd0);
      check("r14_b2b_ready",  32'(req_ready14), 32'b0100);
      check("r14_b2b_sel",    32'(dp_sel14),    32'd2);
      tick();
      req_valid14 = 4'b0000;

`ifdef AES_ROUND_SCHED_PERF_EN
      // ---------------- performance counters ----------------
      do_reset();
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      rounds10("perf1", 2'b01, 0);
      tick();
      rounds10("perf2", 2'b01, 0);
      tick();
      rounds10("perf3", 2'b00, 0);
      tick();
      tick();
      @(negedge clk);
      check("perf_blocks", 32'(perf_blocks),   32'd3);
      check("perf_busy",   perf_busy_cycles,   32'd33);
      tick();
      dut.perf_blocks = 16'hFFFE;
      req_valid = 2'b01;
      rounds10("perf_sat1", 2'b01, 0);
      tick();
      rounds10("perf_sat2", 2'b00, 0);
      tick();
      tick();
      @(negedge clk);
      check("perf_blocks_sat", 32'(perf_blocks), 32'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_aes_round_scheduler
